// File: rtl/mem_bus_arbiter.sv
// Two-port (core/host) round-robin arbiter and 4-phase sequencer for the shared memory bus.
// Define MEM_ARB_HOST_PRIO_EN to make the host win every tie instead of round-robin.
module mem_bus_arbiter #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_ack,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    inout  wire  [DW-1:0] mem_data,
    output logic          mem_oe
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state, state_nx;
    req_t          core_r, host_r, sel_r;
    logic          core_elig, host_elig, take, pick_host;
    logic          gnt_host, lat_we;
    logic [DW-1:0] lat_wdata;
`ifndef MEM_ARB_HOST_PRIO_EN
    logic          last_host;
`endif

    assign core_r    = {core_we, core_addr, core_wdata};
    assign host_r    = {host_we, host_addr, host_wdata};
    assign core_elig = core_req & ~core_ack;
    assign host_elig = host_req & ~host_ack;

`ifdef MEM_ARB_HOST_PRIO_EN
    assign pick_host = host_elig;
`else
    // On a tie the port that did not win last time gets the bus.
    assign pick_host = host_elig & (~core_elig | ~last_host);
`endif
    assign sel_r = pick_host ? host_r : core_r;

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (core_elig | host_elig) begin
                    take     = 1'b1;
                    state_nx = ADDR;
                end
            end
            ADDR:    state_nx = DATA;
            DATA:    state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Outputs are registered from the next-state decision so they line up with the FSM phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr   <= '0;
            mem_write  <= 1'b0;
            mem_oe     <= 1'b0;
            core_ack   <= 1'b0;
            host_ack   <= 1'b0;
            core_rdata <= '0;
            host_rdata <= '0;
            gnt_host   <= 1'b0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
`ifndef MEM_ARB_HOST_PRIO_EN
            last_host  <= 1'b1;
`endif
        end else begin
            mem_write <= take & sel_r.we;
            mem_oe    <= (take & sel_r.we) | ((state == ADDR) & lat_we);
            core_ack  <= (state == DATA) & ~gnt_host;
            host_ack  <= (state == DATA) & gnt_host;
            if (take) begin
                gnt_host  <= pick_host;
                lat_we    <= sel_r.we;
                lat_wdata <= sel_r.wdata;
                mem_addr  <= sel_r.addr;
`ifndef MEM_ARB_HOST_PRIO_EN
                last_host <= pick_host;
`endif
            end
            if ((state == DATA) && !lat_we) begin
                if (gnt_host) host_rdata <= mem_data;
                else          core_rdata <= mem_data;
            end
        end
    end

    assign mem_data = mem_oe ? lat_wdata : {DW{1'bz}};

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer for the stack machine's single shared memory bus (11-bit address, 16-bit bidirectional data). It multiplexes the core port and the host/loader port onto one `mem_addr`/`mem_write`/`mem_data` bus, grants accesses round-robin, and owns the tristate drive of `mem_data`. The host port replaces the loader that currently drives program words onto the bus externally.

## Interface
- `AW`, 11, address width
- `DW`, 16, data width
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `core_req`  in  1  core access request; held high until `core_ack`
- `core_we`  in  1  1 = write, 0 = read; stable while `core_req` is high
- `core_addr`  in  AW  core address
- `core_wdata`  in  DW  core write data
- `core_rdata`  out  DW  read data; valid while `core_ack` is high
- `core_ack`  out  1  one-cycle completion pulse
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_rdata`, `host_ack`: same directions, widths and meanings for the host port
- `mem_addr`  out  AW  memory address
- `mem_write`  out  1  memory write strobe
- `mem_data`  inout  DW  memory data; driven only while `mem_oe` = 1, otherwise high-Z
- `mem_oe`  out  1  arbiter is driving `mem_data`

## Operation
- FSM states: IDLE, ADDR, DATA, ACK.
- IDLE: if any eligible request, latch the winner's `we`/`addr`/`wdata` and go to ADDR; else stay.
- Eligible: `req` high and that port's `ack` not high in the current cycle.
- Round-robin: if both ports are eligible, grant the port not granted last. `last_grant` resets to host, so core wins the first tie.
- ADDR: `mem_addr` = latched address; `mem_write` = latched `we`; on writes `mem_oe` = 1 and `mem_data` = latched wdata. Go to DATA.
- DATA: `mem_addr` held; `mem_write` = 0; write data still driven. On reads, sample `mem_data` into the granted port's `rdata` at the end of the cycle. Go to ACK.
- ACK: granted port's `ack` = 1; `mem_oe` = 0. Go to IDLE.
- `rdata` holds its value until the next read for that port.
- A requester dropping `req` after grant does not abort the access: it completes and still acks.
- Reset asserted mid-access: asynchronous return to IDLE, bus released, no ack.
- Reset values:
  - `mem_addr` = 0, `mem_write` = 0, `mem_oe` = 0, `mem_data` high-Z
  - both `ack` = 0, both `rdata` = 0

## Timing
- Request high in IDLE at cycle 0 → ADDR in cycle 1, DATA in cycle 2, `ack` in cycle 3, IDLE in cycle 4.
- Access latency is 3 cycles from request to ack. Peak throughput is one access per 4 cycles.
- `mem_write` is high in exactly one cycle per write access (ADDR).
- `mem_oe` is high in exactly ADDR and DATA of a write, never on reads.
- At least one non-driven cycle (ACK, IDLE) separates consecutive bus drives, so read/write turnaround is contention-free.
- All outputs are registered. There is no combinational path from `req` to `ack` or to any `mem_*` output.

## Configuration
- `MEM_ARB_HOST_PRIO_EN` defined: fixed priority; host wins every tie and `last_grant` is unused. Host still waits for any in-flight core access to finish.
- Undefined: round-robin as described above.

## Test plan
- Reset: drive `rst` = 0 mid-write. Required: `mem_oe` = 0 and `mem_write` = 0 immediately, with no ack; after release, FSM is IDLE.
- Host write: addr 0x7FE, data 0x0001. Required: `mem_write` = 1 in cycle 1 only, `mem_data` = 0x0001 in cycles 1–2, `host_ack` in cycle 3.
- Core read after host write: core reads addr 0x7FE, with the memory model returning 0x0001. Required: `core_rdata` = 0x0001 with `core_ack` 3 cycles after grant, and `mem_oe` = 0 throughout.
- Simultaneous requests from reset, both held: grant order core, host, core, host. Each ack arrives 4 cycles after the previous one. With `MEM_ARB_HOST_PRIO_EN`, the order is host, host, ….
- Early drop: `core_req` deasserted in ADDR. Required: access completes and `core_ack` still pulses in ACK.
